shift_register_univ: RTL and testbench



---
 rtl/shift_register_univ_pkg.sv | 23 ++
 rtl/shift_register_univ_shift_unit.sv | 29 ++
 rtl/shift_register_univ.sv | 103 ++++++++++
 tb/tb_shift_register_univ.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_univ_pkg.sv
// Shared types and constants for the universal shift register.
package shift_register_univ_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'b000,
    LOAD  = 3'b001,
    SHR   = 3'b010,
    SHL   = 3'b011,
    ROR   = 3'b100,
    ROL   = 3'b101,
    ASR   = 3'b110,
    CLEAR = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_register_univ_shift_unit.sv
// Combinational next-word generator for every register mode.
module shift_unit
  import shift_register_univ_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  mode_e            op,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_word
);

  // LOAD needs the parallel word, so the caller substitutes it; here it holds.
  always_comb begin
    next_word = cur;
    case (op)
      HOLD,
      LOAD:    next_word = cur;
      SHR:     next_word = {serial_in, cur[WIDTH-1:1]};
      SHL:     next_word = {cur[WIDTH-2:0], serial_in};
      ROR:     next_word = {cur[0], cur[WIDTH-1:1]};
      ROL:     next_word = {cur[WIDTH-2:0], cur[WIDTH-1]};
      ASR:     next_word = {cur[WIDTH-1], cur[WIDTH-1:1]};
      CLEAR:   next_word = '0;
      default: next_word = cur;
    endcase
  end

endmodule

// File: rtl/shift_register_univ.sv
// Universal shift register with manual modes and an autonomous serializer.
module shift_register_univ
  import shift_register_univ_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             serial_in,
  input  logic             start,
  input  logic             dir,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   reg_q, reg_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  mode_e              op;
  logic [WIDTH-1:0]   shifted;

  // While serializing, the direction latched at start overrides mode.
  assign op = (state_q == SHIFTING) ? ((dir_q == DIR_LEFT) ? SHL : SHR)
                                    : mode_e'(mode);

  shift_unit #(.WIDTH(WIDTH)) u_shift (
    .cur       (reg_q),
    .op        (op),
    .serial_in (serial_in),
    .next_word (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      reg_q   <= '0;
      dir_q   <= DIR_RIGHT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          reg_d   = data;
          dir_d   = dir;
          cnt_d   = CNT_W'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = SHIFTING;
        end else begin
          reg_d = (op == LOAD) ? data : shifted;
          case (op)
            SHR, ROR, ASR: dir_d = DIR_RIGHT;
            SHL, ROL:      dir_d = DIR_LEFT;
            default:       dir_d = dir_q;
          endcase
        end
      end
      SHIFTING: begin
        reg_d = shifted;
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign serial_out   = (dir_q == DIR_LEFT) ? reg_q[WIDTH-1] : reg_q[0];
  assign parallel_out = reg_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed + randomized bench for shift_register_univ at WIDTH 8 and 12.
module tb_shift_register_univ;
  import shift_register_univ_pkg::*;

  logic        clk, rst;
  logic [2:0]  mode8, mode12;
  logic [7:0]  data8;
  logic [11:0] data12;
  logic        si8, si12, start8, start12, dir8, dir12;
  logic        so8, so12, busy8, busy12, done8, done12;
  logic [7:0]  po8;
  logic [11:0] po12;

  int checks = 0;
  int failures = 0;

  logic [7:0] m8;   // model register contents
  logic       md8;  // model direction flag

  shift_register_univ #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .mode(mode8), .data(data8), .serial_in(si8),
    .start(start8), .dir(dir8), .serial_out(so8), .parallel_out(po8),
    .busy(busy8), .done(done8)
  );

  shift_register_univ #(.WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .mode(mode12), .data(data12), .serial_in(si12),
    .start(start12), .dir(dir12), .serial_out(so12), .parallel_out(po12),
    .busy(busy12), .done(done12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for one manual-mode edge, written as plain arithmetic.
  function automatic logic [7:0] model_op(input logic [2:0] md, input logic [7:0] r,
                                          input logic [7:0] d, input logic si);
    case (md)
      3'd1:    return d;
      3'd2:    return (r >> 1) | (8'(si) << 7);
      3'd3:    return (r << 1) | 8'(si);
      3'd4:    return (r >> 1) | (r << 7);
      3'd5:    return (r << 1) | (r >> 7);
      3'd6:    return 8'($signed(r) >>> 1);
      3'd7:    return 8'd0;
      default: return r;
    endcase
  endfunction

  task automatic manual8(input logic [2:0] md, input logic [7:0] d, input logic si);
    mode8 = md; data8 = d; si8 = si; start8 = 1'b0;
    step();
    m8 = model_op(md, m8, d, si);
    if (md == 3'd2 || md == 3'd4 || md == 3'd6) md8 = 1'b0;
    if (md == 3'd3 || md == 3'd5) md8 = 1'b1;
    chk("manual_po", 32'(po8), 32'(m8));
    chk("manual_so", 32'(so8), 32'(md8 ? m8[7] : m8[0]));
    chk("manual_busy", 32'(busy8), 32'd0);
  endtask

  // One 8-bit serialize; si_kind 0/1 = constant fill, 2 = random; noise pokes ignored inputs.
  task automatic ser8(input logic [7:0] d, input logic dr, input int si_kind, input bit noise);
    logic [7:0] fin;
    logic       si;
    start8 = 1'b1; data8 = d; dir8 = dr; mode8 = 3'($urandom_range(0, 7));
    step();
    start8 = 1'b0; mode8 = 3'd0;
    fin = '0;
    for (int k = 0; k < 8; k++) begin
      chk("ser_busy", 32'(busy8), 32'd1);
      chk("ser_done_low", 32'(done8), 32'd0);
      chk("ser_bit", 32'(so8), 32'(dr ? d[7-k] : d[k]));
      si = (si_kind == 2) ? 1'($urandom) : 1'(si_kind);
      if (dr) fin[7-k] = si; else fin[k] = si;
      si8 = si;
      if (noise) begin
        start8 = 1'($urandom);
        mode8  = 3'd7;
        data8  = 8'($urandom);
        dir8   = 1'($urandom);
      end
      step();
    end
    start8 = 1'b0; mode8 = 3'd0;
    chk("ser_busy_fall", 32'(busy8), 32'd0);
    chk("ser_done", 32'(done8), 32'd1);
    chk("ser_final", 32'(po8), 32'(fin));
    m8 = fin; md8 = dr;
  endtask

  initial begin
    logic [11:0] w12;
    rst = 1'b1;
    mode8 = 3'd0; data8 = '0; si8 = 1'b0; start8 = 1'b0; dir8 = 1'b0;
    mode12 = 3'd0; data12 = '0; si12 = 1'b0; start12 = 1'b0; dir12 = 1'b0;
    m8 = '0; md8 = 1'b0;
    #3;
    chk("rst_po8", 32'(po8), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_so8", 32'(so8), 32'd0);
    chk("rst_po12", 32'(po12), 32'd0);
    #9 rst = 1'b0;
    step();

    // Directed manual-mode sequence
    manual8(LOAD, 8'hB4, 1'b0);  chk("dir_load", 32'(po8), 32'hB4);
    manual8(SHR, 8'h00, 1'b1);   chk("dir_shr", 32'(po8), 32'hDA);
    manual8(ROL, 8'h00, 1'b0);   chk("dir_rol", 32'(po8), 32'hB5);
    manual8(ASR, 8'h00, 1'b1);   chk("dir_asr", 32'(po8), 32'hDA);
    manual8(CLEAR, 8'hFF, 1'b1); chk("dir_clear", 32'(po8), 32'h00);
    manual8(LOAD, 8'h81, 1'b0);
    manual8(HOLD, 8'h00, 1'b0);

    // Randomized manual modes
    for (int i = 0; i < 60; i++)
      manual8(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));

    // LSB-first serialize of 0xA5 with zero fill
    ser8(8'hA5, 1'b0, 0, 1'b0);
    chk("a5_final", 32'(po8), 32'h00);
    step();
    chk("done_one_cycle", 32'(done8), 32'd0);

    // Ignored inputs while busy
    ser8(8'h3C, 1'b1, 2, 1'b1);
    step();
    chk("noise_done_once", 32'(done8), 32'd0);
    chk("noise_idle", 32'(busy8), 32'd0);

    // Back-to-back: start in the done cycle
    ser8(8'($urandom), 1'($urandom), 2, 1'b0);
    ser8(8'($urandom), 1'($urandom), 2, 1'b0);
    ser8(8'($urandom), 1'($urandom), 2, 1'b1);
    step();
    chk("b2b_done_low", 32'(done8), 32'd0);
    chk("b2b_so_idle", 32'(so8), 32'(md8 ? m8[7] : m8[0]));

    // Random serializes interleaved with manual ops
    for (int i = 0; i < 6; i++) begin
      ser8(8'($urandom), 1'($urandom), 2, 1'($urandom));
      manual8(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
    end

    // 12-bit MSB-first serialize of 0x8F3 with one fill
    w12 = 12'h8F3;
    start12 = 1'b1; data12 = w12; dir12 = 1'b1; si12 = 1'b1;
    step();
    start12 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("w12_busy", 32'(busy12), 32'd1);
      chk("w12_bit", 32'(so12), 32'(w12[11-k]));
      step();
    end
    chk("w12_busy_fall", 32'(busy12), 32'd0);
    chk("w12_done", 32'(done12), 32'd1);
    chk("w12_final", 32'(po12), 32'hFFF);
    step();
    chk("w12_done_low", 32'(done12), 32'd0);

    // Asynchronous reset in the middle of a serialize
    start8 = 1'b1; data8 = 8'hFF; dir8 = 1'b1; si8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    chk("pre_rst_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_po8", 32'(po8), 32'd0);
    chk("arst_busy8", 32'(busy8), 32'd0);
    chk("arst_done8", 32'(done8), 32'd0);
    chk("arst_so8", 32'(so8), 32'd0);
    rst = 1'b0;
    m8 = '0; md8 = 1'b0;
    manual8(LOAD, 8'h3C, 1'b0);
    chk("post_rst_load", 32'(po8), 32'h3C);
    manual8(SHL, 8'h00, 1'b1);
    chk("post_rst_shl", 32'(po8), 32'h79);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
